fifo_wptr_ctrl: RTL and testbench

Write-side pointer and flag controller for the graphics core's dual-clock FIFOs. It runs entirely in the write clock domain and accepts push requests. It drives the RAM write address and write strobe, and publishes a registered Gray-coded write pointer for a `crossdomain` synchronizer to carry into the read domain. Its own full, level and almost-full flags come from the read pointer after a `crossdomain` instance has brought it into this domain.

---
 rtl/fifo_wptr_ctrl.sv | 64 ++++++
 tb/tb_fifo_wptr_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_wptr_ctrl.sv
// Write-side pointer and flag controller for a dual-clock FIFO.
// Runs in the write domain; consumes the synchronized Gray read pointer.
module fifo_wptr_ctrl #(
    parameter int unsigned ADDR_BITS         = 4,
    parameter int unsigned ALMOST_FULL_LEVEL = (1 << ADDR_BITS) - 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_BITS:0]   rptr_gray_sync,
    output logic                 push,
    output logic [ADDR_BITS-1:0] waddr,
    output logic [ADDR_BITS:0]   wptr_gray,
    output logic                 full,
    output logic                 almost_full,
    output logic [ADDR_BITS:0]   level,
    output logic                 overflow
);

    localparam int unsigned PW = ADDR_BITS + 1;

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] rgray_full_cmp;
    logic [PW-1:0] level_next;

    assign push  = wr_en & ~full;
    assign waddr = wbin[ADDR_BITS-1:0];

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    assign rgray_full_cmp = rptr_gray_sync ^ (PW'(3) << (ADDR_BITS - 1));

    always_comb begin
        wbin_next  = wbin + PW'(push);
        wgray_next = wbin_next ^ (wbin_next >> 1);
        rbin       = '0;
        rbin[PW-1] = rptr_gray_sync[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ rptr_gray_sync[i];
        end
        level_next = wbin_next - rbin;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wbin        <= '0;
            wptr_gray   <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            level       <= '0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wptr_gray   <= wgray_next;
            full        <= (wgray_next == rgray_full_cmp);
            level       <= level_next;
            almost_full <= (level_next >= PW'(ALMOST_FULL_LEVEL));
            overflow    <= overflow | (wr_en & full);
        end
    end

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Randomized and directed bench for fifo_wptr_ctrl against an occupancy-count model.
module tb_fifo_wptr_ctrl;

    localparam int unsigned AB    = 2;
    localparam int unsigned PW    = AB + 1;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AFL   = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [PW-1:0] rptr_gray_sync;
    logic          push;
    logic [AB-1:0] waddr;
    logic [PW-1:0] wptr_gray;
    logic          full;
    logic          almost_full;
    logic [PW-1:0] level;
    logic          overflow;

    fifo_wptr_ctrl #(.ADDR_BITS(AB), .ALMOST_FULL_LEVEL(AFL)) dut (
        .clk            (clk),
        .reset          (reset),
        .wr_en          (wr_en),
        .rptr_gray_sync (rptr_gray_sync),
        .push           (push),
        .waddr          (waddr),
        .wptr_gray      (wptr_gray),
        .full           (full),
        .almost_full    (almost_full),
        .level          (level),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: total pushes and reads as unbounded counts; everything else derived.
    int   wc, rc;
    int   m_level;
    logic m_full, m_af, m_ovf;
    logic [PW-1:0] prev_gray;
    int   max_level;
    logic saw_full;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] to_gray(input int n);
        logic [PW-1:0] b;
        b = PW'(n % (2 * DEPTH));
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        wc = 0; rc = 0; m_level = 0;
        m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
        prev_gray = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gray"},  32'(wptr_gray),   0);
        check({tag, "_full"},  32'(full),        0);
        check({tag, "_af"},    32'(almost_full), 0);
        check({tag, "_level"}, 32'(level),       0);
        check({tag, "_ovf"},   32'(overflow),    0);
        check({tag, "_waddr"}, 32'(waddr),       0);
    endtask

    // Present inputs for one cycle, check combinational outputs, then registered ones after the edge.
    task automatic apply(input logic we, input logic radv);
        logic p;
        wr_en = we;
        if (radv && rc < wc) rc++;
        rptr_gray_sync = to_gray(rc);
        #1;
        p = we && !m_full;
        check("push",  32'(push),  32'(p));
        check("waddr", 32'(waddr), 32'(wc % DEPTH));
        m_ovf   = m_ovf | (we && m_full);
        wc      = wc + (p ? 1 : 0);
        m_level = wc - rc;
        m_full  = (m_level == DEPTH);
        m_af    = (m_level >= AFL);
        @(posedge clk);
        #1;
        check("gray",     32'(wptr_gray),   32'(to_gray(wc)));
        check("gray_1bit", 32'($countones(wptr_gray ^ prev_gray) <= 1), 1);
        check("full",     32'(full),        32'(m_full));
        check("level",    32'(level),       32'(m_level));
        check("af",       32'(almost_full), 32'(m_af));
        check("ovf",      32'(overflow),    32'(m_ovf));
        prev_gray = wptr_gray;
        if (m_level > max_level) max_level = m_level;
        if (full) saw_full = 1'b1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        check_all_zero(tag);
        model_reset();
        wr_en = 1'b0;
        rptr_gray_sync = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    logic [PW-1:0] exp_gray [4] = '{3'd1, 3'd3, 3'd2, 3'd6};

    initial begin
        reset = 1'b1;
        wr_en = 1'b0;
        rptr_gray_sync = '0;
        model_reset();
        #3;
        do_reset("rst");

        // Fill from empty with the read pointer parked at zero.
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b0);
            check("tp_gray", 32'(wptr_gray), 32'(exp_gray[i]));
            check("tp_level", 32'(level), 32'(i + 1));
        end
        check("tp_full", 32'(full), 1);

        // Push attempts while full are refused and latch overflow.
        apply(1'b1, 1'b0);
        apply(1'b1, 1'b0);
        check("ovf_set", 32'(overflow), 1);
        apply(1'b0, 1'b0);
        check("ovf_sticky", 32'(overflow), 1);

        // Read pointer advance frees one slot; next push refills at address 0.
        apply(1'b0, 1'b1);
        check("rd_full", 32'(full), 0);
        check("rd_level", 32'(level), 3);
        apply(1'b1, 1'b0);
        check("refill_gray", 32'(wptr_gray), 7);
        check("refill_full", 32'(full), 1);

        // Wrap: push then read, eight times, pointer laps without filling.
        do_reset("rst2");
        max_level = 0;
        saw_full  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 1'b0);
            apply(1'b0, 1'b1);
        end
        check("wrap_gray", 32'(wptr_gray), 0);
        check("wrap_waddr", 32'(waddr), 0);
        check("wrap_nofull", 32'(saw_full), 0);
        check("wrap_maxlvl", 32'(max_level <= 2), 1);

        // Final push coincides with a read-pointer advance.
        do_reset("rst3");
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b0);
        check("sim_pre_level", 32'(level), 3);
        apply(1'b1, 1'b1);
        check("sim_full", 32'(full), 0);
        check("sim_level", 32'(level), 3);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            apply(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
        end

        // Asynchronous reset in the middle of a burst.
        do_reset("rst4");
        apply(1'b1, 1'b0);
        apply(1'b1, 1'b0);
        check("mid_level", 32'(level), 2);
        wr_en = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async");
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        apply(1'b1, 1'b0);
        check("post_rst_gray", 32'(wptr_gray), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
